sdram_burst_scheduler: RTL and testbench

Sequences and shares the single SDRAM port between the capture write path (ADC samples into SDRAM) and the readout path (SDRAM to SPI). Drives the go/base/length controls of both the write and read Avalon masters and tracks write and read pointers over a circular buffer. Prevents reads of unwritten data and flags capture overruns. Sits between the capture/SPI logic and the two SDRAM master control interfaces.

---
 rtl/sdram_burst_scheduler_if.sv | 44 ++++
 rtl/sdram_burst_scheduler.sv | 174 +++++++++++++++++
 tb/tb_sdram_burst_scheduler.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_burst_scheduler_if.sv
// ---------------------------------------------------------------------------
// sdram_burst_scheduler_if
// Bundles the request/grant handshake, the two SDRAM master control buses
// and the buffer status of the burst scheduler.
//   slave  modport : used by the scheduler (requests and master done in,
//                    grants, master controls and status out)
//   master modport : used by the surrounding capture/SPI/master logic
// ---------------------------------------------------------------------------
interface sdram_burst_scheduler_if;
    logic        wr_req;
    logic        rd_req;
    logic        clear;
    logic        wr_grant;
    logic        rd_grant;
    logic        wr_done;
    logic        rd_done;
    logic        write_control_go;
    logic [31:0] write_control_base;
    logic [31:0] write_control_length;
    logic        write_control_done;
    logic        read_control_go;
    logic [31:0] read_control_base;
    logic [31:0] read_control_length;
    logic        read_control_done;
    logic [31:0] fill_bytes;
    logic        busy;
    logic        overflow;

    modport slave (
        input  wr_req, rd_req, clear, write_control_done, read_control_done,
        output wr_grant, rd_grant, wr_done, rd_done,
        output write_control_go, write_control_base, write_control_length,
        output read_control_go, read_control_base, read_control_length,
        output fill_bytes, busy, overflow
    );

    modport master (
        output wr_req, rd_req, clear, write_control_done, read_control_done,
        input  wr_grant, rd_grant, wr_done, rd_done,
        input  write_control_go, write_control_base, write_control_length,
        input  read_control_go, read_control_base, read_control_length,
        input  fill_bytes, busy, overflow
    );
endinterface

// File: rtl/sdram_burst_scheduler.sv
// ---------------------------------------------------------------------------
// sdram_burst_scheduler
// Shares one SDRAM port between the capture write path and the SPI readout
// path. Launches one burst at a time on the write or read Avalon master,
// tracks write/read pointers over a circular buffer, refuses reads of
// unwritten data and flags capture overruns.
//   clk      : system clock, rising edge
//   reset_n  : synchronous active-low reset
//   bus      : request/grant handshake, master go/base/length/done,
//              fill_bytes, busy, overflow (slave modport)
// ---------------------------------------------------------------------------
module sdram_burst_scheduler #(
    parameter int          BURST_BYTES = 64,
    parameter logic [31:0] MEM_BYTES   = 32'h0400_0000,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    sdram_burst_scheduler_if.slave       bus
);

    localparam logic [31:0] BURST    = 32'(BURST_BYTES);
    localparam logic [31:0] PTR_MASK = MEM_BYTES - 32'd1;
    localparam logic [31:0] FILL_MAX = MEM_BYTES - BURST;

    typedef enum logic [1:0] {S_IDLE, S_GO, S_ARM, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic        dir_q, dir_d;            // 0 = write master, 1 = read master
    logic        last_dir_q, last_dir_d;
    logic [31:0] wr_ptr_q, wr_ptr_d;
    logic [31:0] rd_ptr_q, rd_ptr_d;
    logic [31:0] fill_q, fill_d;
    logic [31:0] wr_base_q, wr_base_d;
    logic [31:0] rd_base_q, rd_base_d;
    logic        overflow_q, overflow_d;
    logic        clr_pend_q, clr_pend_d;
    logic        wr_done_q, wr_done_d;
    logic        rd_done_q, rd_done_d;

    logic        write_ok;
    logic        read_ok;
    logic        pick_rd;
    logic        sel_done;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            dir_q      <= 1'b0;
            last_dir_q <= 1'b1;           // first contest goes to write
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            wr_base_q  <= BASE_ADDR;
            rd_base_q  <= BASE_ADDR;
            overflow_q <= 1'b0;
            clr_pend_q <= 1'b0;
            wr_done_q  <= 1'b0;
            rd_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            last_dir_q <= last_dir_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            wr_base_q  <= wr_base_d;
            rd_base_q  <= rd_base_d;
            overflow_q <= overflow_d;
            clr_pend_q <= clr_pend_d;
            wr_done_q  <= wr_done_d;
            rd_done_q  <= rd_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        last_dir_d = last_dir_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        wr_base_d  = wr_base_q;
        rd_base_d  = rd_base_q;
        overflow_d = overflow_q;
        clr_pend_d = clr_pend_q;
        wr_done_d  = 1'b0;
        rd_done_d  = 1'b0;
        pick_rd    = 1'b0;

        write_ok = bus.wr_req && (fill_q <= FILL_MAX);
        read_ok  = bus.rd_req && (fill_q >= BURST);
        sel_done = dir_q ? bus.read_control_done : bus.write_control_done;

        // A clear arriving mid-burst is held until the burst retires.
        if (bus.clear && (state_q != S_IDLE)) begin
            clr_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.clear) begin
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    fill_d     = '0;
                    overflow_d = 1'b0;
                end else begin
                    if (bus.wr_req && (fill_q > FILL_MAX)) begin
                        overflow_d = 1'b1;
                    end
                    if (write_ok || read_ok) begin
                        // Round-robin only matters when both are eligible.
                        pick_rd    = (write_ok && read_ok) ? ~last_dir_q : read_ok;
                        dir_d      = pick_rd;
                        last_dir_d = pick_rd;
                        if (pick_rd) begin
                            rd_base_d = BASE_ADDR + rd_ptr_q;
                        end else begin
                            wr_base_d = BASE_ADDR + wr_ptr_q;
                        end
                        state_d = S_GO;
                    end
                end
            end
            S_GO: begin
                state_d = S_ARM;
            end
            S_ARM: begin
                // done falling means the master has taken the command.
                if (!sel_done) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sel_done) begin
                    state_d   = S_IDLE;
                    wr_done_d = ~dir_q;
                    rd_done_d = dir_q;
                    if (bus.clear || clr_pend_q) begin
                        wr_ptr_d   = '0;
                        rd_ptr_d   = '0;
                        fill_d     = '0;
                        overflow_d = 1'b0;
                        clr_pend_d = 1'b0;
                    end else if (dir_q) begin
                        rd_ptr_d = (rd_ptr_q + BURST) & PTR_MASK;
                        fill_d   = fill_q - BURST;
                    end else begin
                        wr_ptr_d = (wr_ptr_q + BURST) & PTR_MASK;
                        fill_d   = fill_q + BURST;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.write_control_go     = (state_q == S_GO) && !dir_q;
    assign bus.read_control_go      = (state_q == S_GO) &&  dir_q;
    assign bus.wr_grant             = bus.write_control_go;
    assign bus.rd_grant             = bus.read_control_go;
    assign bus.wr_done              = wr_done_q;
    assign bus.rd_done              = rd_done_q;
    assign bus.write_control_base   = wr_base_q;
    assign bus.read_control_base    = rd_base_q;
    assign bus.write_control_length = BURST;
    assign bus.read_control_length  = BURST;
    assign bus.fill_bytes           = fill_q;
    assign bus.busy                 = (state_q != S_IDLE);
    assign bus.overflow             = overflow_q;

endmodule

// File: tb/tb_sdram_burst_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sdram_burst_scheduler
// Directed bench for sdram_burst_scheduler with a 256-byte buffer and
// 64-byte bursts. Each SDRAM master is modelled as: done high while idle,
// drops 2 cycles after go, rises again 16 cycles after go.
// ---------------------------------------------------------------------------
module tb_sdram_burst_scheduler;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    sdram_burst_scheduler_if bus();

    sdram_burst_scheduler #(
        .BURST_BYTES (64),
        .MEM_BYTES   (32'd256),
        .BASE_ADDR   (32'h0)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write master model
    initial begin
        bus.write_control_done = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.write_control_go === 1'b1) begin
                repeat (2) @(negedge clk);
                bus.write_control_done = 1'b0;
                repeat (14) @(negedge clk);
                bus.write_control_done = 1'b1;
            end
        end
    end

    // Read master model
    initial begin
        bus.read_control_done = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.read_control_go === 1'b1) begin
                repeat (2) @(negedge clk);
                bus.read_control_done = 1'b0;
                repeat (14) @(negedge clk);
                bus.read_control_done = 1'b1;
            end
        end
    end

    typedef struct {
        bit          do_rst;
        bit          wr;
        bit          rd;
        bit          exp_rd;
        logic [31:0] exp_base;
        logic [31:0] exp_fill;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        bus.clear  = 1'b0;
        reset_n    = 1'b0;
        repeat (2) @(negedge clk);
        reset_n    = 1'b1;
    endtask

    task automatic wait_grant(output bit got_rd, output bit ok);
        ok     = 1'b0;
        got_rd = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.wr_grant || bus.rd_grant) begin
                ok     = 1'b1;
                got_rd = bus.rd_grant;
                break;
            end
        end
    endtask

    task automatic wait_done(output bit got_rd, output bit ok);
        ok     = 1'b0;
        got_rd = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (bus.wr_done || bus.rd_done) begin
                ok     = 1'b1;
                got_rd = bus.rd_done;
                break;
            end
        end
    endtask

    // Called at a falling edge; returns at the falling edge of the done pulse.
    task automatic burst(input string tag, input bit wr, input bit rd, input bit exp_rd,
                         input logic [31:0] exp_base, input logic [31:0] exp_fill);
        bit got_rd;
        bit ok;
        bus.wr_req = wr;
        bus.rd_req = rd;
        wait_grant(got_rd, ok);
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        check({tag, "_grant_seen"}, 32'(ok), 32'd1);
        if (ok) begin
            check({tag, "_dir"}, 32'(got_rd), 32'(exp_rd));
            check({tag, "_base"}, exp_rd ? bus.read_control_base : bus.write_control_base, exp_base);
            check({tag, "_idle_go"}, 32'(exp_rd ? bus.write_control_go : bus.read_control_go), 32'd0);
            check({tag, "_busy"}, 32'(bus.busy), 32'd1);
            wait_done(got_rd, ok);
            check({tag, "_done_seen"}, 32'(ok), 32'd1);
            if (ok) begin
                check({tag, "_done_dir"}, 32'(got_rd), 32'(exp_rd));
                check({tag, "_fill"}, bus.fill_bytes, exp_fill);
            end
        end
    endtask

    task automatic run_row(input int i);
        vec_t v;
        v = vecs[i];
        if (v.do_rst) do_reset();
        burst($sformatf("row%0d", i), v.wr, v.rd, v.exp_rd, v.exp_base, v.exp_fill);
    endtask

    initial begin
        bit got_rd;
        bit ok;
        bit seen;
        int cnt;

        total = 0;
        bad   = 0;

        //           rst wr rd exp_rd base    fill
        vecs[0]  = '{1, 1, 0, 0, 32'h00, 32'd64};
        vecs[1]  = '{0, 1, 0, 0, 32'h40, 32'd128};
        vecs[2]  = '{0, 1, 1, 1, 32'h00, 32'd64};
        vecs[3]  = '{0, 1, 1, 0, 32'h80, 32'd128};
        vecs[4]  = '{0, 1, 1, 1, 32'h40, 32'd64};
        vecs[5]  = '{0, 1, 1, 0, 32'hC0, 32'd128};
        vecs[6]  = '{0, 1, 1, 1, 32'h80, 32'd64};
        vecs[7]  = '{1, 1, 0, 0, 32'h00, 32'd64};
        vecs[8]  = '{0, 1, 0, 0, 32'h40, 32'd128};
        vecs[9]  = '{0, 1, 0, 0, 32'h80, 32'd192};
        vecs[10] = '{0, 1, 0, 0, 32'hC0, 32'd256};
        vecs[11] = '{0, 0, 1, 1, 32'h00, 32'd192};
        vecs[12] = '{0, 0, 1, 1, 32'h40, 32'd128};
        vecs[13] = '{0, 0, 1, 1, 32'h80, 32'd64};
        vecs[14] = '{0, 0, 1, 1, 32'hC0, 32'd0};
        vecs[15] = '{0, 1, 0, 0, 32'h00, 32'd64};
        vecs[16] = '{0, 1, 0, 0, 32'h40, 32'd128};

        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        bus.clear  = 1'b0;
        reset_n    = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_wr_go",    32'(bus.write_control_go), 32'd0);
        check("rst_rd_go",    32'(bus.read_control_go), 32'd0);
        check("rst_wr_grant", 32'(bus.wr_grant), 32'd0);
        check("rst_rd_grant", 32'(bus.rd_grant), 32'd0);
        check("rst_wr_done",  32'(bus.wr_done), 32'd0);
        check("rst_rd_done",  32'(bus.rd_done), 32'd0);
        check("rst_wr_base",  bus.write_control_base, 32'h0);
        check("rst_rd_base",  bus.read_control_base, 32'h0);
        check("rst_wr_len",   bus.write_control_length, 32'd64);
        check("rst_rd_len",   bus.read_control_length, 32'd64);
        check("rst_fill",     bus.fill_bytes, 32'd0);
        check("rst_busy",     32'(bus.busy), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        reset_n = 1'b1;

        // Back-to-back writes, then round-robin contest
        for (int i = 0; i <= 10; i++) run_row(i);

        // Buffer full: further write must be refused and flagged
        check("full_ovf_before", 32'(bus.overflow), 32'd0);
        bus.wr_req = 1'b1;
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.wr_grant || bus.write_control_go) cnt++;
        end
        bus.wr_req = 1'b0;
        check("full_no_grant", 32'(cnt), 32'd0);
        check("full_overflow", 32'(bus.overflow), 32'd1);
        check("full_fill",     bus.fill_bytes, 32'd256);

        // Drain with wrap, write at wrapped pointer, one more write
        for (int i = 11; i <= 16; i++) run_row(i);
        check("ovf_sticky", 32'(bus.overflow), 32'd1);

        // Clear during a read burst's WAIT
        bus.rd_req = 1'b1;
        wait_grant(got_rd, ok);
        bus.rd_req = 1'b0;
        check("clrw_grant_rd", 32'(ok && got_rd), 32'd1);
        check("clrw_base", bus.read_control_base, 32'h00);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (!bus.read_control_done) begin
                ok = 1'b1;
                break;
            end
        end
        check("clrw_master_busy", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        check("clrw_busy", 32'(bus.busy), 32'd1);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        check("clrw_fill_held", bus.fill_bytes, 32'd128);
        wait_done(got_rd, ok);
        check("clrw_rd_done", 32'(ok && got_rd), 32'd1);
        check("clrw_fill", bus.fill_bytes, 32'd0);
        check("clrw_overflow", 32'(bus.overflow), 32'd0);
        burst("clrw_wr", 1'b1, 1'b0, 1'b0, 32'h00, 32'd64);
        burst("clrw_rd", 1'b0, 1'b1, 1'b1, 32'h00, 32'd0);

        // Clear in IDLE with a simultaneous write request
        burst("clri_pre", 1'b1, 1'b0, 1'b0, 32'h40, 32'd64);
        bus.clear  = 1'b1;
        bus.wr_req = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        check("clri_busy",  32'(bus.busy), 32'd0);
        check("clri_grant", 32'(bus.wr_grant), 32'd0);
        check("clri_fill",  bus.fill_bytes, 32'd0);
        burst("clri_post", 1'b1, 1'b0, 1'b0, 32'h00, 32'd64);

        // Empty buffer: read request must never launch
        do_reset();
        bus.rd_req = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.read_control_go || bus.busy) seen = 1'b1;
        end
        bus.rd_req = 1'b0;
        check("empty_rd_no_go", 32'(seen), 32'd0);

        // Reset mid-WAIT
        burst("rstw_pre", 1'b1, 1'b0, 1'b0, 32'h00, 32'd64);
        bus.wr_req = 1'b1;
        wait_grant(got_rd, ok);
        bus.wr_req = 1'b0;
        check("rstw_grant_wr", 32'(ok && !got_rd), 32'd1);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (!bus.write_control_done) begin
                ok = 1'b1;
                break;
            end
        end
        check("rstw_master_busy", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("rstw_busy",  32'(bus.busy), 32'd0);
        check("rstw_wr_go", 32'(bus.write_control_go), 32'd0);
        check("rstw_rd_go", 32'(bus.read_control_go), 32'd0);
        check("rstw_fill",  bus.fill_bytes, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
